// File: rtl/counter_ssd_scan.sv
// counter_ssd_scan
//   N-digit up/down counter with synchronous load, count enable and a
//   one-cycle wrap flag, plus a multiplexed active-low 7-segment display scan.
//
//   Build option: define COUNTER_SSD_BCD_EN for BCD counting (each digit
//   0..9, ripple carry/borrow, load nibbles saturated to 9). Left undefined,
//   the counter is plain binary modulo 2^(4*DIGITS).
//
// Parameters
//   DIGITS       number of 4-bit digits counted and displayed (1..8)
//   REFRESH_DIV  clocks each digit stays lit before the scan advances (>=1)
//
// Ports
//   clock      in   system clock, all state on posedge
//   reset      in   asynchronous active-high reset
//   en         in   count enable, one step per clock while high
//   u_or_down  in   1 = count up, 0 = count down
//   load       in   synchronous load of load_val (overrides en)
//   load_val   in   load value, nibble i = digit i
//   Q          out  current count (registered)
//   wrap       out  one-cycle pulse together with a wrapped Q
//   C          out  segments {g,f,e,d,c,b,a}, active-low (registered)
//   AN         out  digit anodes, active-low one-hot (registered)

module counter_ssd_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  u_or_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  wrap,
  output logic [6:0]            C,
  output logic [DIGITS-1:0]     AN
);

  localparam int W  = 4 * DIGITS;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [RW-1:0] REFRESH_TC = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Segment pattern for one hex nibble, {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Nibble i of v. A compare-and-select loop keeps index widths explicit.
  function automatic logic [3:0] nibble_at(input logic [W-1:0] v,
                                           input logic [DW-1:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == DW'(k)) r = v[4*k +: 4];
    end
    return r;
  endfunction

  // Active-low one-hot anode pattern for digit i.
  function automatic logic [DIGITS-1:0] anode_for(input logic [DW-1:0] i);
    logic [DIGITS-1:0] a;
    for (int k = 0; k < DIGITS; k++) begin
      a[k] = (i != DW'(k));
    end
    return a;
  endfunction

`ifdef COUNTER_SSD_BCD_EN
  // One BCD step across all digits; bit W is the carry/borrow out of the top
  // digit, which is exactly the wrap condition (all nines up, all zeros down).
  function automatic logic [W:0] count_step(input logic [W-1:0] v,
                                            input logic up);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (up) begin
          if (d >= 4'd9) begin
            r[4*k +: 4] = 4'd0;
            c = 1'b1;
          end else begin
            r[4*k +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*k +: 4] = 4'd9;
            c = 1'b1;
          end else begin
            r[4*k +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  // Load values outside 0..9 are clamped per digit so Q is always valid BCD.
  function automatic logic [W-1:0] load_format(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
    end
    return r;
  endfunction
`else
  // Binary step with one extra bit: up carries out of all-ones, down borrows
  // out of zero, so bit W is the wrap condition in both directions.
  function automatic logic [W:0] count_step(input logic [W-1:0] v,
                                            input logic up);
    logic [W:0] r;
    if (up) r = {1'b0, v} + (W+1)'(1);
    else    r = {1'b0, v} - (W+1)'(1);
    return r;
  endfunction

  function automatic logic [W-1:0] load_format(input logic [W-1:0] v);
    return v;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Counter and scan state
  // ---------------------------------------------------------------------------
  logic [RW-1:0] refresh_cnt;
  logic [DW-1:0] digit_sel;

  logic [W:0]    step_res;
  logic [W-1:0]  load_fmt;
  logic          refresh_tc;
  logic [DW-1:0] digit_sel_nxt;

  always_comb begin
    step_res      = count_step(Q, u_or_down);
    load_fmt      = load_format(load_val);
    refresh_tc    = (refresh_cnt == REFRESH_TC);
    digit_sel_nxt = digit_sel;
    if (refresh_tc) begin
      digit_sel_nxt = (digit_sel == LAST_DIGIT) ? '0 : digit_sel + DW'(1);
    end
  end

  // C is decoded from the Q value present before this edge, so the display
  // trails a count change by one cycle; C and AN are both registered so they
  // switch on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Q           <= '0;
      wrap        <= 1'b0;
      refresh_cnt <= '0;
      digit_sel   <= '0;
      AN          <= anode_for('0);
      C           <= 7'b1000000;
    end else begin
      if (load) begin
        Q    <= load_fmt;
        wrap <= 1'b0;
      end else if (en) begin
        Q    <= step_res[W-1:0];
        wrap <= step_res[W];
      end else begin
        wrap <= 1'b0;
      end

      refresh_cnt <= refresh_tc ? '0 : refresh_cnt + RW'(1);
      digit_sel   <= digit_sel_nxt;
      AN          <= anode_for(digit_sel_nxt);
      C           <= seg_decode(nibble_at(Q, digit_sel_nxt));
    end
  end

endmodule
